// File: rtl/go_pkg.sv
// rtl/go_pkg.sv - shared Go board types for the game sequencer slice
// Purpose: cell/board/move types, the pass encoding and the reject codes
//          shared by game_sequencer, its arbiter and its updater interface.
// Ports:   none (package).
package go_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } cell_t;

  // board[row][col]
  typedef cell_t [8:0][8:0] board_t;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } move_t;

  localparam logic [7:0] PASS_MOVE = 8'hFF;

  typedef enum logic [1:0] {
    REJ_OCCUPIED  = 2'd0,
    REJ_OFF_BOARD = 2'd1,
    REJ_TIMEOUT   = 2'd2,
    REJ_KO        = 2'd3
  } reject_code_t;

endpackage

// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - sequencer <-> board_updater bus
// Purpose: groups the board_updater handshake and board buses.
// Ports (master = game_sequencer side):
//   upd_start      out  1-cycle start pulse
//   upd_turn       out  turn of the move in flight (1=white)
//   upd_move       out  move in flight
//   upd_board      out  committed board
//   upd_next_board in   updater result
//   upd_ready      in   updater done
interface game_sequencer_if;
  import go_pkg::*;

  logic       upd_start;
  logic       upd_turn;
  logic [7:0] upd_move;
  board_t     upd_board;
  board_t     upd_next_board;
  logic       upd_ready;

  modport master (
    output upd_start, upd_turn, upd_move, upd_board,
    input  upd_next_board, upd_ready
  );

  modport slave (
    input  upd_start, upd_turn, upd_move, upd_board,
    output upd_next_board, upd_ready
  );
endinterface

// File: rtl/move_arbiter.sv
// rtl/move_arbiter.sv - turn-gated valid/ready mux of the black/white sources
// Purpose: only the side to move ever sees ready; emits the selected move
//          and an accept pulse on the handshake.
// Ports:
//   en               in   sequencer can take a move (IDLE)
//   turn             in   side to move (0=black)
//   b_valid/b_move   in   black source;   b_ready out
//   w_valid/w_move   in   white source;   w_ready out
//   sel_move         out  move of the side to move
//   accept           out  handshake completed this cycle
module move_arbiter (
  input  logic       en,
  input  logic       turn,
  input  logic       b_valid,
  input  logic [7:0] b_move,
  output logic       b_ready,
  input  logic       w_valid,
  input  logic [7:0] w_move,
  output logic       w_ready,
  output logic [7:0] sel_move,
  output logic       accept
);
  assign b_ready  = en && !turn && b_valid;
  assign w_ready  = en &&  turn && w_valid;
  assign accept   = b_ready || w_ready;
  assign sel_move = turn ? w_move : b_move;
endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - turn controller in front of board_updater
// Purpose: accepts the side-to-move's move, legality-checks it, sequences
//          board_updater, commits the result and tracks turn/passes/game end.
// Optional feature: macro GAME_KO_CHECK_EN adds prev_board and the KO state.
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   b_valid/b_move/b_ready    black move source (8'hFF = pass)
//   w_valid/w_move/w_ready    white move source
//   upd                       board_updater bus (game_sequencer_if.master)
//   turn_out                  side to move (0=black)
//   move_count                committed moves incl. passes, saturating
//   game_over                 sticky after two consecutive passes
//   reject, reject_code       1-cycle refusal pulse and its reason
module game_sequencer
  import go_pkg::*;
#(
  parameter int UPD_TIMEOUT = 4096,
  parameter int MAX_MOVES   = 361
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    b_valid,
  input  logic [7:0]              b_move,
  output logic                    b_ready,
  input  logic                    w_valid,
  input  logic [7:0]              w_move,
  output logic                    w_ready,
  game_sequencer_if.master        upd,
  output logic                    turn_out,
  output logic [8:0]              move_count,
  output logic                    game_over,
  output logic                    reject,
  output logic [1:0]              reject_code
);
  localparam int TW = $clog2(UPD_TIMEOUT);

  typedef enum logic [2:0] {IDLE, CHECK, START, WAIT, KO, COMMIT, OVER} state_t;

  state_t       state, state_nx;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]   pass_cnt;
  move_t        cur_move;
  board_t       board;
  logic         accept;
  logic [7:0]   sel_move;
  logic         do_commit, do_pass, do_reject;
  reject_code_t rej_nx;

`ifdef GAME_KO_CHECK_EN
  // all-2'b11 means "no previous board": can never equal a real board
  logic [8:0][8:0][1:0] prev_board;
`endif

  move_arbiter u_arb (
    .en       (state == IDLE),
    .turn     (turn_out),
    .b_valid  (b_valid),
    .b_move   (b_move),
    .b_ready  (b_ready),
    .w_valid  (w_valid),
    .w_move   (w_move),
    .w_ready  (w_ready),
    .sel_move (sel_move),
    .accept   (accept)
  );

  assign upd.upd_start = (state == START);
  assign upd.upd_turn  = turn_out;
  assign upd.upd_move  = cur_move;
  assign upd.upd_board = board;

  always_comb begin
    state_nx  = state;
    do_commit = 1'b0;
    do_pass   = 1'b0;
    do_reject = 1'b0;
    rej_nx    = REJ_OCCUPIED;
    case (state)
      IDLE:  if (accept) state_nx = CHECK;
      CHECK: begin
        if (cur_move == PASS_MOVE) begin
          do_pass  = 1'b1;
          state_nx = (pass_cnt != 2'd0) ? OVER : IDLE;
        end else if (cur_move.row > 4'd8 || cur_move.col > 4'd8) begin
          do_reject = 1'b1;
          rej_nx    = REJ_OFF_BOARD;
          state_nx  = IDLE;
        end else if (board[cur_move.row][cur_move.col] != EMPTY) begin
          do_reject = 1'b1;
          rej_nx    = REJ_OCCUPIED;
          state_nx  = IDLE;
        end else begin
          state_nx = START;
        end
      end
      START: state_nx = WAIT;
      WAIT: begin
        // upd_ready has priority over the timeout
        if (upd.upd_ready) begin
`ifdef GAME_KO_CHECK_EN
          state_nx = KO;
`else
          do_commit = 1'b1;
          state_nx  = COMMIT;
`endif
        end else if (tmo_cnt == TW'(UPD_TIMEOUT - 1)) begin
          do_reject = 1'b1;
          rej_nx    = REJ_TIMEOUT;
          state_nx  = IDLE;
        end
      end
      KO: begin
`ifdef GAME_KO_CHECK_EN
        if (upd.upd_next_board == prev_board) begin
          do_reject = 1'b1;
          rej_nx    = REJ_KO;
          state_nx  = IDLE;
        end else begin
          do_commit = 1'b1;
          state_nx  = COMMIT;
        end
`else
        state_nx = IDLE;
`endif
      end
      COMMIT: state_nx = IDLE;
      OVER:   state_nx = OVER;
      default: state_nx = IDLE;
    endcase
  end

  // Commit happens on the edge entering COMMIT, so turn_out changes one
  // cycle after upd_ready (one more with the KO check in between).
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      pass_cnt    <= 2'd0;
      cur_move    <= '0;
      board       <= board_t'('0);
      turn_out    <= 1'b0;
      move_count  <= 9'd0;
      game_over   <= 1'b0;
      reject      <= 1'b0;
      reject_code <= 2'd0;
`ifdef GAME_KO_CHECK_EN
      prev_board  <= '1;
`endif
    end else begin
      state   <= state_nx;
      tmo_cnt <= (state == WAIT) ? tmo_cnt + TW'(1) : '0;
      reject  <= do_reject;
      if (do_reject) reject_code <= rej_nx;
      if (accept) cur_move <= sel_move;
      if (do_commit || do_pass) begin
        if (move_count != 9'(MAX_MOVES)) move_count <= move_count + 9'd1;
      end
      if (do_commit) begin
        board    <= upd.upd_next_board;
        turn_out <= ~turn_out;
        pass_cnt <= 2'd0;
`ifdef GAME_KO_CHECK_EN
        prev_board <= board;
`endif
      end
      if (do_pass) begin
        if (pass_cnt != 2'd3) pass_cnt <= pass_cnt + 2'd1;
        if (pass_cnt != 2'd0) game_over <= 1'b1;
        else                  turn_out  <= ~turn_out;
`ifdef GAME_KO_CHECK_EN
        prev_board <= '1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized self-checking bench for game_sequencer
module tb_game_sequencer;
  import go_pkg::*;

  localparam int UPD_TIMEOUT = 4096;
  localparam int MAX_MOVES   = 361;

  typedef logic [161:0] val_t;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       b_valid, w_valid, b_ready, w_ready;
  logic [7:0] b_move, w_move;
  logic       turn_out, game_over, reject;
  logic [8:0] move_count;
  logic [1:0] reject_code;

  game_sequencer_if upd();

  game_sequencer #(.UPD_TIMEOUT(UPD_TIMEOUT), .MAX_MOVES(MAX_MOVES)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .b_valid     (b_valid),
    .b_move      (b_move),
    .b_ready     (b_ready),
    .w_valid     (w_valid),
    .w_move      (w_move),
    .w_ready     (w_ready),
    .upd         (upd),
    .turn_out    (turn_out),
    .move_count  (move_count),
    .game_over   (game_over),
    .reject      (reject),
    .reject_code (reject_code)
  );

  always #5 clk_in = ~clk_in;

  // reference model: the game as rules, not as hardware
  logic [1:0] mb [9][9];
  logic [1:0] mp [9][9];
  bit m_turn, m_over, m_last_pass, m_prev_ok;
  int m_count;
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input val_t got, input val_t exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic val_t pack(input logic [1:0] b [9][9]);
    val_t v = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        v[(r*9+c)*2 +: 2] = b[r][c];
    return v;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_turn"},  val_t'(turn_out),   val_t'(m_turn));
    check({tag, "_count"}, val_t'(move_count), val_t'(m_count));
    check({tag, "_over"},  val_t'(game_over),  val_t'(m_over));
    check({tag, "_board"}, val_t'(upd.upd_board), pack(mb));
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1; b_valid = 1'b0; w_valid = 1'b0; upd.upd_ready = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) mb[r][c] = 2'b00;
    m_turn = 0; m_count = 0; m_over = 0; m_last_pass = 0; m_prev_ok = 0;
    #1;
    check_state("rst");
    check("rst_reject", val_t'(reject), val_t'(0));
    check("rst_code",   val_t'(reject_code), val_t'(0));
    check("rst_start",  val_t'(upd.upd_start), val_t'(0));
  endtask

  // Off-turn side offers a move: must never be taken.
  task automatic gate(input bit side, input logic [7:0] mv, input int cycles);
    @(negedge clk_in);
    if (side) begin w_valid = 1'b1; w_move = mv; end
    else      begin b_valid = 1'b1; b_move = mv; end
    for (int i = 0; i < cycles; i++) begin
      #1;
      check("gate_ready",  val_t'(side ? w_ready : b_ready), val_t'(0));
      check("gate_start",  val_t'(upd.upd_start), val_t'(0));
      check("gate_reject", val_t'(reject), val_t'(0));
      @(negedge clk_in);
    end
    b_valid = 1'b0; w_valid = 1'b0;
    check_state("gate");
  endtask

  // delay < 0: updater never answers. ko_stub: updater returns prior board.
  task automatic play(input bit side, input logic [7:0] mv, input int delay, input bit ko_stub);
    logic [3:0] r, c;
    logic [1:0] nb [9][9];
    bit ko_rej;
    int n;
    r = mv[7:4]; c = mv[3:0];
    @(negedge clk_in);
    if (side) begin w_valid = 1'b1; w_move = mv; end
    else      begin b_valid = 1'b1; b_move = mv; end
    #1;
    check("ready", val_t'(side ? w_ready : b_ready), val_t'(1));
    @(negedge clk_in);
    b_valid = 1'b0; w_valid = 1'b0;
    check("start_early", val_t'(upd.upd_start), val_t'(0));
    check("upd_move", val_t'(upd.upd_move), val_t'(mv));
    if (mv == 8'hFF) begin
      @(negedge clk_in);
      m_count = (m_count == MAX_MOVES) ? m_count : m_count + 1;
      if (m_last_pass) m_over = 1;
      else begin m_turn = !m_turn; m_last_pass = 1; end
      m_prev_ok = 0;
      check("pass_reject", val_t'(reject), val_t'(0));
      check_state("pass");
    end else if (r > 8 || c > 8 || mb[r][c] != 2'b00) begin
      @(negedge clk_in);
      check("ill_reject", val_t'(reject), val_t'(1));
      check("ill_code", val_t'(reject_code), val_t'((r > 8 || c > 8) ? 1 : 0));
      check_state("ill");
    end else begin
      @(negedge clk_in);
      check("start", val_t'(upd.upd_start), val_t'(1));
      check("upd_turn", val_t'(upd.upd_turn), val_t'(m_turn));
      if (delay < 0) begin
        n = 0;
        do begin
          @(negedge clk_in);
          n++;
        end while (!reject && n < UPD_TIMEOUT + 20);
        check("tmo_cycles", val_t'(n), val_t'(UPD_TIMEOUT + 1));
        check("tmo_code", val_t'(reject_code), val_t'(2));
        check_state("tmo");
      end else begin
        @(negedge clk_in);
        check("start_pulse", val_t'(upd.upd_start), val_t'(0));
        repeat (delay - 1) @(negedge clk_in);
        if (ko_stub) nb = mp;
        else begin
          nb = mb;
          nb[r][c] = m_turn ? 2'b10 : 2'b01;
        end
        upd.upd_next_board = board_t'(pack(nb));
        upd.upd_ready = 1'b1;
        @(negedge clk_in);
        upd.upd_ready = 1'b0;
        ko_rej = 0;
`ifdef GAME_KO_CHECK_EN
        @(negedge clk_in);
        ko_rej = m_prev_ok && (pack(nb) == pack(mp));
`endif
        if (ko_rej) begin
          check("ko_reject", val_t'(reject), val_t'(1));
          check("ko_code", val_t'(reject_code), val_t'(3));
        end else begin
          check("commit_reject", val_t'(reject), val_t'(0));
          mp = mb; m_prev_ok = 1; mb = nb;
          m_turn = !m_turn;
          m_count = (m_count == MAX_MOVES) ? m_count : m_count + 1;
          m_last_pass = 0;
        end
        check_state("commit");
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] mv;
    int sel;
    rst_in = 1'b1; b_valid = 1'b0; w_valid = 1'b0; b_move = 8'h00; w_move = 8'h00;
    upd.upd_ready = 1'b0;
    upd.upd_next_board = board_t'('0);
    do_reset();

    gate(1'b1, 8'h00, 6);
    play(1'b0, 8'h44, 3, 1'b0);
    play(1'b1, 8'h00, 2, 1'b0);
    play(1'b0, 8'h44, 1, 1'b0);
    play(1'b0, 8'h9A, 1, 1'b0);
    play(1'b0, 8'h22, -1, 1'b0);
    play(1'b0, 8'h22, 2, 1'b0);
    play(1'b1, 8'h66, 2, 1'b1);

    for (int i = 0; i < 40; i++) begin
      if (m_over) do_reset();
      sel = $urandom_range(0, 19);
      if (sel == 0)      mv = 8'hFF;
      else if (sel == 1) mv = {4'($urandom_range(9, 15)), 4'($urandom_range(0, 15))};
      else               mv = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 8))};
      if ($urandom_range(0, 9) == 0) gate(!m_turn, mv, 3);
      else play(m_turn, mv, $urandom_range(1, 6), m_prev_ok && ($urandom_range(0, 5) == 0));
    end

    do_reset();
    play(1'b0, 8'hFF, 1, 1'b0);
    play(1'b1, 8'hFF, 1, 1'b0);
    check("over_flag", val_t'(game_over), val_t'(1));
    check("over_count", val_t'(move_count), val_t'(2));
    @(negedge clk_in);
    b_valid = 1'b1; w_valid = 1'b1; b_move = 8'h11; w_move = 8'h12;
    repeat (3) begin
      #1;
      check("over_b_ready", val_t'(b_ready), val_t'(0));
      check("over_w_ready", val_t'(w_ready), val_t'(0));
      @(negedge clk_in);
    end
    b_valid = 1'b0; w_valid = 1'b0;
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
